// File: rtl/bus_pkg.sv
// Shared bus definitions: packet field helpers, transaction kinds and FIFO statistics.
package bus_pkg;

  localparam int          PKT_W        = 16;
  localparam logic [7:0]  BROADCAST_ID = 8'hFF;

  typedef enum logic [1:0] {
    LECTURA,
    ESCRITURA,
    LECT_ESCR,
    RESET
  } tipo_trans;

  typedef struct packed {
    logic [15:0] count;
    logic [15:0] overflow_cnt;
  } fifo_stats_t;

  // Destination ID lives in the top byte of the packet.
  function automatic logic [7:0] get_dest(input logic [PKT_W-1:0] pkt);
    return pkt[PKT_W-1 -: 8];
  endfunction

endpackage

// File: rtl/dev_fifo_ram.sv
// Storage for dev_port_fifo: one synchronous write port, one asynchronous read port.
module dev_fifo_ram #(
  parameter int width = 16,
  parameter int depth = 8,
  localparam int AW   = $clog2(depth)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [width-1:0] o_rdata
);

  // Contents are intentionally not reset.
  logic [width-1:0] r_mem [depth];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dev_port_fifo.sv
// Per-device ingress FIFO in front of the bus arbiter; drops the oldest packet when
// pushed while full, and keeps occupancy, loss and underflow status.
module dev_port_fifo
  import bus_pkg::*;
#(
  parameter int         width = 16,
  parameter int         depth = 8,
  parameter logic [7:0] id    = 8'd0,
  localparam int        AW    = $clog2(depth),
  localparam int        CW    = $clog2(depth) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] D_push,
  input  logic             pop,
  output logic [width-1:0] D_pop,
  output logic             pndng,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic [15:0]      overflow_cnt,
  output logic             underflow,
  output logic [7:0]       self_id
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_ovf_cnt;
  logic          r_underflow;

  logic w_pndng;
  logic w_full;
  logic w_we;
  logic w_pop_ok;
  logic w_drop;
  logic w_inc;
  logic w_dec;

  assign w_pndng  = (r_count != '0);
  assign w_full   = (r_count == CW'(depth));
  assign w_we     = rst_n & push;
  assign w_pop_ok = pop & w_pndng;
  assign w_drop   = push & w_full & ~pop;
  // push+pop on an empty FIFO behaves as a plain push
  assign w_inc    = push & ((~pop & ~w_full) | (pop & ~w_pndng));
  assign w_dec    = w_pop_ok & ~push;

  dev_fifo_ram #(
    .width (width),
    .depth (depth)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (D_push),
    .i_raddr (r_rd_ptr),
    .o_rdata (D_pop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ovf_cnt   <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= pop & ~w_pndng;
      if (push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok || w_drop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_inc) begin
        r_count <= r_count + CW'(1);
      end else if (w_dec) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
    end
  end

  assign pndng        = w_pndng;
  assign full         = w_full;
  assign count        = r_count;
  assign overflow_cnt = r_ovf_cnt;
  assign underflow    = r_underflow;
  assign self_id      = id;

endmodule

// File: tb/tb_dev_port_fifo.sv
// Self-checking bench for dev_port_fifo against a queue-based packet model.
module tb_dev_port_fifo;
  import bus_pkg::*;

  localparam int         W     = 16;
  localparam int         DEPTH = 8;
  localparam logic [7:0] ID    = 8'h5A;

  logic          clk;
  logic          rst_n;
  logic          push;
  logic [W-1:0]  D_push;
  logic          pop;
  logic [W-1:0]  D_pop;
  logic          pndng;
  logic          full;
  logic [3:0]    count;
  logic [15:0]   overflow_cnt;
  logic          underflow;
  logic [7:0]    self_id;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mq[$];
  int           m_ovf = 0;
  bit           m_uf  = 0;

  dev_port_fifo #(.width(W), .depth(DEPTH), .id(ID)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .D_push       (D_push),
    .pop          (pop),
    .D_pop        (D_pop),
    .pndng        (pndng),
    .full         (full),
    .count        (count),
    .overflow_cnt (overflow_cnt),
    .underflow    (underflow),
    .self_id      (self_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive, let the edge happen, advance the model, release inputs.
  task automatic step(input bit p, input bit pp, input bit rst, input logic [W-1:0] d);
    push   = p;
    pop    = pp;
    rst_n  = ~rst;
    D_push = d;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_uf  = 0;
    end else begin
      m_uf = pp && (mq.size() == 0);
      if (pp && mq.size() > 0) void'(mq.pop_front());
      if (p) begin
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          if (m_ovf < 65535) m_ovf++;
        end
        mq.push_back(d);
      end
    end
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic xact(input tipo_trans t, input logic [W-1:0] d);
    case (t)
      ESCRITURA: step(1, 0, 0, d);
      LECTURA:   step(0, 1, 0, d);
      LECT_ESCR: step(1, 1, 0, d);
      default:   step(0, 0, 1, d);
    endcase
  endtask

  task automatic idle();
    step(0, 0, 0, '0);
  endtask

  task automatic test_reset();
    xact(RESET, '0);
    xact(RESET, '0);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (pndng !== 1'b0) begin n_fail++; $display("FAIL reset_pndng got %b want 0", pndng); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_checks++; if (overflow_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_ovf got %0d want 0", overflow_cnt); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_uf got %b want 0", underflow); end
    n_checks++; if (self_id !== ID) begin n_fail++; $display("FAIL self_id got %h want %h", self_id, ID); end
  endtask

  task automatic test_single_push();
    xact(RESET, '0);
    xact(ESCRITURA, 16'h0211);
    n_checks++; if (pndng !== 1'b1) begin n_fail++; $display("FAIL single_pndng got %b want 1", pndng); end
    n_checks++; if (D_pop !== 16'h0211) begin n_fail++; $display("FAIL single_dpop got %h want 0211", D_pop); end
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
    n_checks++; if (get_dest(D_pop) !== 8'h02) begin n_fail++; $display("FAIL single_dest got %h want 02", get_dest(D_pop)); end
  endtask

  task automatic test_fill_drain();
    xact(RESET, '0);
    for (int i = 0; i < 8; i++) xact(ESCRITURA, 16'h0100 + 16'(i));
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count got %0d want 8", count); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (D_pop !== 16'h0100 + 16'(i)) begin
        n_fail++; $display("FAIL drain_order idx %0d got %h want %h", i, D_pop, 16'h0100 + 16'(i));
      end
      xact(LECTURA, '0);
    end
    n_checks++; if (pndng !== 1'b0) begin n_fail++; $display("FAIL drain_pndng got %b want 0", pndng); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_seq[8];
    xact(RESET, '0);
    for (int i = 0; i < 8; i++) xact(ESCRITURA, 16'h0100 + 16'(i));
    xact(ESCRITURA, 16'h0AAA);
    xact(ESCRITURA, 16'h0BBB);
    n_checks++; if (overflow_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_cnt got %0d want 2", overflow_cnt); end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d want 8", count); end
    for (int i = 0; i < 6; i++) exp_seq[i] = 16'h0102 + 16'(i);
    exp_seq[6] = 16'h0AAA;
    exp_seq[7] = 16'h0BBB;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (D_pop !== exp_seq[i]) begin
        n_fail++; $display("FAIL ovf_order idx %0d got %h want %h", i, D_pop, exp_seq[i]);
      end
      xact(LECTURA, '0);
    end
    n_checks++; if (overflow_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_hold got %0d want 2", overflow_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    xact(RESET, '0);
    for (int i = 0; i < 3; i++) xact(ESCRITURA, 16'($urandom));
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (D_pop !== mq[0]) begin n_fail++; $display("FAIL b2b_head cyc %0d got %h want %h", i, D_pop, mq[0]); end
      d = 16'($urandom);
      xact(LECT_ESCR, d);
      n_checks++;
      if (count !== 4'd3) begin n_fail++; $display("FAIL b2b_count cyc %0d got %0d want 3", i, count); end
    end
    n_checks++; if (overflow_cnt !== 16'd0) begin n_fail++; $display("FAIL b2b_ovf got %0d want 0", overflow_cnt); end
    // also exercise push+pop while full: no drop expected
    while (mq.size() < DEPTH) xact(ESCRITURA, 16'($urandom));
    for (int i = 0; i < 10; i++) begin
      d = 16'($urandom);
      xact(LECT_ESCR, d);
      n_checks++;
      if (count !== 4'd8 || overflow_cnt !== 16'd0 || D_pop !== mq[0]) begin
        n_fail++; $display("FAIL b2b_full cyc %0d count %0d ovf %0d dpop %h want 8 0 %h", i, count, overflow_cnt, D_pop, mq[0]);
      end
    end
  endtask

  task automatic test_underflow();
    xact(RESET, '0);
    xact(LECTURA, '0);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_pulse got %b want 1", underflow); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL uf_count got %0d want 0", count); end
    idle();
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_width got %b want 0", underflow); end
    xact(LECT_ESCR, 16'h0F0F);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL uf_pp_count got %0d want 1", count); end
    n_checks++; if (D_pop !== 16'h0F0F) begin n_fail++; $display("FAIL uf_pp_dpop got %h want 0F0F", D_pop); end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_pp_pulse got %b want 1", underflow); end
  endtask

  task automatic test_reset_mid();
    xact(RESET, '0);
    for (int i = 0; i < 9; i++) xact(ESCRITURA, 16'h0300 + 16'(i));
    for (int i = 0; i < 3; i++) xact(LECTURA, '0);
    n_checks++;
    if (count !== 4'd5 || overflow_cnt !== 16'd1) begin
      n_fail++; $display("FAIL rmid_pre count %0d ovf %0d want 5 1", count, overflow_cnt);
    end
    step(1, 0, 1, 16'h0ABC);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL rmid_count got %0d want 0", count); end
    n_checks++; if (pndng !== 1'b0) begin n_fail++; $display("FAIL rmid_pndng got %b want 0", pndng); end
    n_checks++; if (overflow_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_ovf got %0d want 0", overflow_cnt); end
    xact(ESCRITURA, 16'h00FF);
    n_checks++; if (D_pop !== 16'h00FF) begin n_fail++; $display("FAIL rmid_dpop got %h want 00FF", D_pop); end
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL rmid_count1 got %0d want 1", count); end
  endtask

  task automatic test_random();
    bit p, pp, r;
    xact(RESET, '0);
    for (int i = 0; i < 400; i++) begin
      p  = ($urandom_range(0, 99) < 55);
      pp = ($urandom_range(0, 99) < 45);
      r  = ($urandom_range(0, 99) < 2);
      step(p, pp, r, 16'($urandom));
      n_checks++;
      if (count !== 4'(mq.size()) || pndng !== (mq.size() != 0) || full !== (mq.size() == DEPTH)
          || overflow_cnt !== 16'(m_ovf) || underflow !== m_uf) begin
        n_fail++;
        $display("FAIL rand_state cyc %0d count %0d pndng %b full %b ovf %0d uf %b want %0d %b %b %0d %b",
                 i, count, pndng, full, overflow_cnt, underflow, mq.size(), mq.size() != 0,
                 mq.size() == DEPTH, m_ovf, m_uf);
      end
      if (mq.size() > 0) begin
        n_checks++;
        if (D_pop !== mq[0]) begin n_fail++; $display("FAIL rand_head cyc %0d got %h want %h", i, D_pop, mq[0]); end
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    D_push = '0;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_overflow();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
